// File: rtl/mimo_pkg.sv
// Shared types for the 8-lane branch-tagged gather reader.
// Lane/branch widths, FSM states and the in-flight read tag.
package mimo_pkg;

    localparam int NUM_LANES = 8;
    localparam int BRANCH_W  = 3;
    localparam int LANE_W    = 3;

    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_LANES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        HOLD
    } gather_state_t;

    typedef struct packed {
        logic                vld;
        logic [LANE_W-1:0]   lane;
        logic [BRANCH_W-1:0] branch;
    } rd_tag_t;

    function automatic logic [NUM_LANES-1:0] branch_onehot(
        input logic [BRANCH_W-1:0] b
    );
        return NUM_LANES'(1) << b;
    endfunction

endpackage

// File: rtl/rd_tag_delay.sv
// Tag shift register matching the memory read latency.
// Synchronous clear drops every in-flight tag on reset.
module rd_tag_delay
    import mimo_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    i_clock,
    input  logic    i_reset,
    input  rd_tag_t i_tag,
    output rd_tag_t o_tag
);

    rd_tag_t stage_q [DEPTH];
    rd_tag_t stage_d [DEPTH];

    always_comb begin
        stage_d[0] = i_tag;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    assign o_tag = stage_q[DEPTH-1];

endmodule

// File: rtl/mimo_gather_8.sv
// 8-lane gather reader: one read per cycle, fixed-latency return capture.
// Define MIMO_GATHER_OVERLAP_EN to accept the next beat during the output handshake.
module mimo_gather_8
    import mimo_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int RD_LATENCY = 2
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic [ADDR_WIDTH-1:0] i_addr_0,
    input  logic [ADDR_WIDTH-1:0] i_addr_1,
    input  logic [ADDR_WIDTH-1:0] i_addr_2,
    input  logic [ADDR_WIDTH-1:0] i_addr_3,
    input  logic [ADDR_WIDTH-1:0] i_addr_4,
    input  logic [ADDR_WIDTH-1:0] i_addr_5,
    input  logic [ADDR_WIDTH-1:0] i_addr_6,
    input  logic [ADDR_WIDTH-1:0] i_addr_7,
    input  logic [2:0]            i_from_branch_0,
    input  logic [2:0]            i_from_branch_1,
    input  logic [2:0]            i_from_branch_2,
    input  logic [2:0]            i_from_branch_3,
    input  logic [2:0]            i_from_branch_4,
    input  logic [2:0]            i_from_branch_5,
    input  logic [2:0]            i_from_branch_6,
    input  logic [2:0]            i_from_branch_7,
    input  logic                  i_valid,
    output logic                  o_ready,
    output logic [ADDR_WIDTH-1:0] o_rd_addr,
    output logic                  o_rd_en_0,
    output logic                  o_rd_en_1,
    output logic                  o_rd_en_2,
    output logic                  o_rd_en_3,
    output logic                  o_rd_en_4,
    output logic                  o_rd_en_5,
    output logic                  o_rd_en_6,
    output logic                  o_rd_en_7,
    input  logic [WIDTH-1:0]      i_rd_data_0,
    input  logic [WIDTH-1:0]      i_rd_data_1,
    input  logic [WIDTH-1:0]      i_rd_data_2,
    input  logic [WIDTH-1:0]      i_rd_data_3,
    input  logic [WIDTH-1:0]      i_rd_data_4,
    input  logic [WIDTH-1:0]      i_rd_data_5,
    input  logic [WIDTH-1:0]      i_rd_data_6,
    input  logic [WIDTH-1:0]      i_rd_data_7,
    output logic [WIDTH-1:0]      o_data_0,
    output logic [WIDTH-1:0]      o_data_1,
    output logic [WIDTH-1:0]      o_data_2,
    output logic [WIDTH-1:0]      o_data_3,
    output logic [WIDTH-1:0]      o_data_4,
    output logic [WIDTH-1:0]      o_data_5,
    output logic [WIDTH-1:0]      o_data_6,
    output logic [WIDTH-1:0]      o_data_7,
    output logic                  o_valid,
    input  logic                  i_ready
);

    logic [ADDR_WIDTH-1:0] addr_in   [NUM_LANES];
    logic [BRANCH_W-1:0]   branch_in [NUM_LANES];
    logic [WIDTH-1:0]      rd_data   [NUM_LANES];

    assign addr_in = '{i_addr_0, i_addr_1, i_addr_2, i_addr_3,
                       i_addr_4, i_addr_5, i_addr_6, i_addr_7};
    assign branch_in = '{i_from_branch_0, i_from_branch_1,
                         i_from_branch_2, i_from_branch_3,
                         i_from_branch_4, i_from_branch_5,
                         i_from_branch_6, i_from_branch_7};
    assign rd_data = '{i_rd_data_0, i_rd_data_1, i_rd_data_2, i_rd_data_3,
                       i_rd_data_4, i_rd_data_5, i_rd_data_6, i_rd_data_7};

    gather_state_t         state_q, state_d;
    logic [LANE_W-1:0]     cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q   [NUM_LANES];
    logic [ADDR_WIDTH-1:0] addr_d   [NUM_LANES];
    logic [BRANCH_W-1:0]   branch_q [NUM_LANES];
    logic [BRANCH_W-1:0]   branch_d [NUM_LANES];
    logic [WIDTH-1:0]      lane_q   [NUM_LANES];
    logic [WIDTH-1:0]      lane_d   [NUM_LANES];
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [NUM_LANES-1:0]  rd_en_q, rd_en_d;
    logic                  valid_q, valid_d;
    rd_tag_t               tag_q, tag_d;
    rd_tag_t               ret_tag;
    logic                  accept;

    // The tag enters the delay line aligned with its registered read enable.
    rd_tag_delay #(
        .DEPTH (RD_LATENCY)
    ) u_tag_delay (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_tag   (tag_q),
        .o_tag   (ret_tag)
    );

`ifdef MIMO_GATHER_OVERLAP_EN
    assign o_ready = !i_reset &&
                     ((state_q == IDLE) || ((state_q == HOLD) && i_ready));
`else
    assign o_ready = !i_reset && (state_q == IDLE);
`endif

    assign accept = i_valid && o_ready;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        branch_d  = branch_q;
        lane_d    = lane_q;
        rd_addr_d = rd_addr_q;
        rd_en_d   = '0;
        tag_d     = '0;
        valid_d   = valid_q;

        if (ret_tag.vld) begin
            lane_d[ret_tag.lane] = rd_data[ret_tag.branch];
        end

        // Lane 0 issues on the handshake edge itself.
        if (accept) begin
            addr_d       = addr_in;
            branch_d     = branch_in;
            rd_addr_d    = addr_in[0];
            rd_en_d      = branch_onehot(branch_in[0]);
            tag_d.vld    = 1'b1;
            tag_d.lane   = '0;
            tag_d.branch = branch_in[0];
            cnt_d        = LANE_W'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                rd_addr_d    = addr_q[cnt_q];
                rd_en_d      = branch_onehot(branch_q[cnt_q]);
                tag_d.vld    = 1'b1;
                tag_d.lane   = cnt_q;
                tag_d.branch = branch_q[cnt_q];
                cnt_d        = cnt_q + LANE_W'(1);
                if (cnt_q == LAST_LANE) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (ret_tag.vld && (ret_tag.lane == LAST_LANE)) begin
                    valid_d = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (i_ready) begin
                    valid_d = 1'b0;
                    state_d = accept ? ISSUE : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '{default: '0};
            branch_q  <= '{default: '0};
            lane_q    <= '{default: '0};
            rd_addr_q <= '0;
            rd_en_q   <= '0;
            tag_q     <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            branch_q  <= branch_d;
            lane_q    <= lane_d;
            rd_addr_q <= rd_addr_d;
            rd_en_q   <= rd_en_d;
            tag_q     <= tag_d;
            valid_q   <= valid_d;
        end
    end

    assign o_rd_addr = rd_addr_q;
    assign o_valid   = valid_q;

    assign o_rd_en_0 = rd_en_q[0];
    assign o_rd_en_1 = rd_en_q[1];
    assign o_rd_en_2 = rd_en_q[2];
    assign o_rd_en_3 = rd_en_q[3];
    assign o_rd_en_4 = rd_en_q[4];
    assign o_rd_en_5 = rd_en_q[5];
    assign o_rd_en_6 = rd_en_q[6];
    assign o_rd_en_7 = rd_en_q[7];

    assign o_data_0 = lane_q[0];
    assign o_data_1 = lane_q[1];
    assign o_data_2 = lane_q[2];
    assign o_data_3 = lane_q[3];
    assign o_data_4 = lane_q[4];
    assign o_data_5 = lane_q[5];
    assign o_data_6 = lane_q[6];
    assign o_data_7 = lane_q[7];

endmodule

// File: tb/tb_mimo_gather_8.sv
// Randomized bench for mimo_gather_8 against a beat-level reference model.
// Memory responder: mem[b][a] = b<<16 | a, garbage whenever not addressed.
module tb_mimo_gather_8;

    localparam int LAT = 2;
`ifdef MIMO_GATHER_OVERLAP_EN
    localparam int PERIOD = 9 + LAT;
    localparam int BP_GAP = 0;
`else
    localparam int PERIOD = 10 + LAT;
    localparam int BP_GAP = 1;
`endif

    typedef struct packed {
        logic [31:0]      vcyc;
        logic [7:0][31:0] d;
    } beat_t;

    logic        clk = 1'b0;
    logic        i_reset;
    logic        i_valid;
    logic        i_ready;
    logic        o_ready;
    logic        o_valid;
    logic [9:0]  o_rd_addr;
    wire  [7:0]  rd_en_vec;
    logic [9:0]  req_addr [8];
    logic [2:0]  req_br   [8];
    logic [31:0] rd_data  [8];
    wire  [31:0] o_data   [8];

    int     cyc = 0;
    int     total = 0;
    int     bad = 0;
    bit     armed = 1'b0;
    bit     rdy_rand = 1'b0;
    int     t0, t1, t2;
    beat_t  beat_q [$];
    int     rise_q [$];
    logic [7:0] exp_en   [64];
    logic [9:0] exp_addr [64];
    logic [7:0] hist_en   [16];
    logic [9:0] hist_addr [16];
    logic       prev_valid = 1'b0;

    mimo_gather_8 #(
        .WIDTH      (32),
        .ADDR_WIDTH (10),
        .RD_LATENCY (LAT)
    ) dut (
        .i_clock         (clk),
        .i_reset         (i_reset),
        .i_addr_0        (req_addr[0]),
        .i_addr_1        (req_addr[1]),
        .i_addr_2        (req_addr[2]),
        .i_addr_3        (req_addr[3]),
        .i_addr_4        (req_addr[4]),
        .i_addr_5        (req_addr[5]),
        .i_addr_6        (req_addr[6]),
        .i_addr_7        (req_addr[7]),
        .i_from_branch_0 (req_br[0]),
        .i_from_branch_1 (req_br[1]),
        .i_from_branch_2 (req_br[2]),
        .i_from_branch_3 (req_br[3]),
        .i_from_branch_4 (req_br[4]),
        .i_from_branch_5 (req_br[5]),
        .i_from_branch_6 (req_br[6]),
        .i_from_branch_7 (req_br[7]),
        .i_valid         (i_valid),
        .o_ready         (o_ready),
        .o_rd_addr       (o_rd_addr),
        .o_rd_en_0       (rd_en_vec[0]),
        .o_rd_en_1       (rd_en_vec[1]),
        .o_rd_en_2       (rd_en_vec[2]),
        .o_rd_en_3       (rd_en_vec[3]),
        .o_rd_en_4       (rd_en_vec[4]),
        .o_rd_en_5       (rd_en_vec[5]),
        .o_rd_en_6       (rd_en_vec[6]),
        .o_rd_en_7       (rd_en_vec[7]),
        .i_rd_data_0     (rd_data[0]),
        .i_rd_data_1     (rd_data[1]),
        .i_rd_data_2     (rd_data[2]),
        .i_rd_data_3     (rd_data[3]),
        .i_rd_data_4     (rd_data[4]),
        .i_rd_data_5     (rd_data[5]),
        .i_rd_data_6     (rd_data[6]),
        .i_rd_data_7     (rd_data[7]),
        .o_data_0        (o_data[0]),
        .o_data_1        (o_data[1]),
        .o_data_2        (o_data[2]),
        .o_data_3        (o_data[3]),
        .o_data_4        (o_data[4]),
        .o_data_5        (o_data[5]),
        .o_data_6        (o_data[6]),
        .o_data_7        (o_data[7]),
        .o_valid         (o_valid),
        .i_ready         (i_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem(input int b, input logic [9:0] a);
        return (32'(b) << 16) | 32'(a);
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Memory responder: data only on the one cycle the reader expects it.
    always @(negedge clk) begin
        int s;
        int p;
        s = cyc % 16;
        p = (cyc + 16 - LAT) % 16;
        hist_en[s]   = rd_en_vec;
        hist_addr[s] = o_rd_addr;
        for (int b = 0; b < 8; b++) begin
            if (cyc >= LAT && hist_en[p][b] === 1'b1)
                rd_data[b] = mem(b, hist_addr[p]);
            else
                rd_data[b] = $urandom;
        end
    end

    always @(posedge clk) begin
        #1;
        if (rdy_rand) i_ready = 1'($urandom_range(0, 1));
    end

    // Reference model: beat queue plus a per-cycle read-enable schedule.
    always @(negedge clk) begin
        if (armed) begin
            int    s;
            logic  exp_vld;
            logic  exp_rdy;
            beat_t nb;
            s = cyc % 64;
            exp_vld = (beat_q.size() > 0) && (cyc >= int'(beat_q[0].vcyc));
            exp_rdy = !i_reset && (beat_q.size() == 0);
`ifdef MIMO_GATHER_OVERLAP_EN
            if (!i_reset && exp_vld && i_ready) exp_rdy = 1'b1;
`endif
            chk("rd_en", 32'(rd_en_vec), 32'(exp_en[s]));
            if (exp_en[s] != 0) chk("rd_addr", 32'(o_rd_addr), 32'(exp_addr[s]));
            exp_en[s] = '0;
            chk("o_valid", 32'(o_valid), 32'(exp_vld));
            chk("o_ready", 32'(o_ready), 32'(exp_rdy));
            if (exp_vld) begin
                for (int k = 0; k < 8; k++)
                    chk($sformatf("o_data_%0d", k), o_data[k], beat_q[0].d[k]);
            end
            if (o_valid && !prev_valid) rise_q.push_back(cyc);
            prev_valid = o_valid;
            if (i_reset) begin
                beat_q.delete();
                for (int j = 1; j <= 16; j++) exp_en[(cyc + j) % 64] = '0;
            end else begin
                if (exp_vld && i_ready) void'(beat_q.pop_front());
                if (i_valid && exp_rdy) begin
                    nb.vcyc = 32'(cyc + 9 + LAT);
                    for (int k = 0; k < 8; k++) begin
                        nb.d[k] = mem(int'(req_br[k]), req_addr[k]);
                        exp_en[(cyc + 1 + k) % 64] |= 8'(1) << req_br[k];
                        exp_addr[(cyc + 1 + k) % 64] = req_addr[k];
                    end
                    beat_q.push_back(nb);
                end
            end
        end
    end

    task automatic to_cyc(input int n);
        do @(negedge clk); while (cyc < n);
    endtask

    // Holds i_valid until accepted; returns the acceptance cycle.
    task automatic send_beat(output int t);
        bit done;
        done = 1'b0;
        t = -1;
        i_valid = 1'b1;
        for (int n = 0; n < 100 && !done; n++) begin
            @(negedge clk);
            if (o_ready) begin
                t = cyc;
                done = 1'b1;
            end
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got none want handshake");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rand_req();
        for (int k = 0; k < 8; k++) begin
            req_addr[k] = 10'($urandom);
            req_br[k]   = 3'($urandom);
        end
    endtask

    task automatic idle(input int n);
        i_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) exp_en[i] = '0;
        for (int k = 0; k < 8; k++) begin
            req_addr[k] = '0;
            req_br[k]   = '0;
        end
        i_reset = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_o_ready", 32'(o_ready), 32'd0);
        chk("rst_o_valid", 32'(o_valid), 32'd0);
        chk("rst_rd_en", 32'(rd_en_vec), 32'd0);
        chk("rst_rd_addr", 32'(o_rd_addr), 32'd0);
        chk("rst_o_data_0", o_data[0], 32'd0);
        @(posedge clk);
        #1;
        i_reset = 1'b0;
        i_ready = 1'b1;
        armed = 1'b1;

        // Identity beat with literal timing pins.
        for (int k = 0; k < 8; k++) begin
            req_addr[k] = 10'(k);
            req_br[k]   = 3'(k);
        end
        send_beat(t0);
        i_valid = 1'b0;
        to_cyc(t0 + 1);
        chk("id_rd_en_first", 32'(rd_en_vec), 32'h01);
        to_cyc(t0 + 8);
        chk("id_rd_en_last", 32'(rd_en_vec), 32'h80);
        to_cyc(t0 + 10);
        chk("id_valid_early", 32'(o_valid), 32'd0);
        to_cyc(t0 + 11);
        chk("id_valid_rise", 32'(o_valid), 32'd1);
        chk("id_data_5", o_data[5], 32'h0005_0005);
        chk("id_data_7", o_data[7], 32'h0007_0007);
        to_cyc(t0 + 12);
        chk("id_idle_ready", 32'(o_ready), 32'd1);
        @(posedge clk);
        #1;

        // All lanes from branch 3.
        for (int k = 0; k < 8; k++) begin
            req_addr[k] = 10'(16 + k);
            req_br[k]   = 3'd3;
        end
        send_beat(t0);
        i_valid = 1'b0;
        to_cyc(t0 + 4);
        chk("b3_rd_en", 32'(rd_en_vec), 32'h08);
        to_cyc(t0 + 11);
        chk("b3_data_0", o_data[0], 32'h0003_0010);
        chk("b3_data_7", o_data[7], 32'h0003_0017);
        idle(3);

        // Backpressure in HOLD, then next beat queued behind it.
        i_ready = 1'b0;
        rand_req();
        send_beat(t0);
        i_valid = 1'b0;
        to_cyc(t0 + 16);
        chk("bp_hold_valid", 32'(o_valid), 32'd1);
        chk("bp_hold_ready", 32'(o_ready), 32'd0);
        @(posedge clk);
        #1;
        i_ready = 1'b1;
        rand_req();
        send_beat(t1);
        chk("bp_next_accept", 32'(t1), 32'(t0 + 17 + BP_GAP));
        idle(20);

        // Reset in the middle of issuing.
        rand_req();
        send_beat(t0);
        i_valid = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        i_reset = 1'b1;
        @(posedge clk);
        #1;
        i_reset = 1'b0;
        to_cyc(t0 + 6);
        chk("rst_mid_rd_en", 32'(rd_en_vec), 32'd0);
        idle(15);
        rand_req();
        send_beat(t0);
        idle(20);

        // Random beats with random backpressure and gaps.
        rdy_rand = 1'b1;
        for (int n = 0; n < 25; n++) begin
            rand_req();
            send_beat(t0);
            idle($urandom_range(0, 3));
        end
        rdy_rand = 1'b0;
        i_ready = 1'b1;
        idle(30);

        // Back-to-back throughput.
        rise_q.delete();
        for (int n = 0; n < 3; n++) begin
            rand_req();
            send_beat(t0);
        end
        i_valid = 1'b0;
        t2 = 0;
        while (rise_q.size() < 3 && t2 < 100) begin
            @(negedge clk);
            t2++;
        end
        if (rise_q.size() < 3) begin
            total++;
            bad++;
            $display("FAIL period_timeout: got %0d rises want 3", rise_q.size());
        end else begin
            chk("period_1", 32'(rise_q[1] - rise_q[0]), 32'(PERIOD));
            chk("period_2", 32'(rise_q[2] - rise_q[1]), 32'(PERIOD));
        end
        idle(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
